// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_loader_pkg;

  // Loader sequencing: two header bytes, payload, trailing checksum byte.
  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    CHECK,
    DONE,
    ERR
  } loader_state_t;

  // Number of little-endian length bytes ahead of the payload.
  localparam int HDR_BYTES = 2;

  // Running checksum is a plain modulo-256 byte sum.
  localparam int CKSUM_WIDTH = 8;

endpackage

// File: rtl/imem_loader.sv
// Boot-time loader: takes a length-prefixed, checksummed byte stream and
// writes the payload into instruction memory, holding the core in reset
// until a load finishes with a good checksum.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 12,
  parameter int DATA_WIDTH    = 8,
  parameter int MAX_BYTES     = 4096
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [DATA_WIDTH-1:0]    rx_data,
  input  logic                     rx_valid,
  output logic                     rx_ready,
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  output logic                     cpu_hold,
  output logic                     busy,
  output logic                     done,
  output logic                     error
);

  // One extra bit so a full 2**ADDRESS_WIDTH byte payload can be counted
  // without the counter wrapping back to zero.
  localparam int LEN_W = ADDRESS_WIDTH + 1;
  localparam int HDR_W = HDR_BYTES * DATA_WIDTH;

  loader_state_t          state;
  logic [DATA_WIDTH-1:0]  len_lo;
  logic [LEN_W-1:0]       length;
  logic [LEN_W-1:0]       counter;
  logic [CKSUM_WIDTH-1:0] checksum;

  logic                   xfer;
  logic [HDR_W-1:0]       hdr_len;
  logic                   hdr_bad;
  logic [CKSUM_WIDTH-1:0] cksum_next;
  logic                   last_byte;

  assign xfer       = rx_valid && rx_ready;
  assign hdr_len    = {rx_data, len_lo};
  assign hdr_bad    = (hdr_len == '0) || (hdr_len > HDR_W'(MAX_BYTES));
  assign cksum_next = checksum + CKSUM_WIDTH'(rx_data);
  assign last_byte  = (counter == (length - LEN_W'(1)));

  // The loader is willing to take a byte in any stream-consuming state,
  // regardless of whether the source is currently offering one.
  always_comb begin
    rx_ready = 1'b0;
    case (state)
      LEN_LO, LEN_HI, DATA, CHECK: rx_ready = 1'b1;
      default:                     rx_ready = 1'b0;
    endcase
  end

  // Main sequencer; every status output is registered and changes on the
  // same edge that enters the corresponding state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      len_lo    <= '0;
      length    <= '0;
      counter   <= '0;
      checksum  <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      cpu_hold  <= 1'b1;
    end else begin
      mem_we <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= LEN_LO;
            busy  <= 1'b1;
          end
        end

        LEN_LO: begin
          if (xfer) begin
            len_lo <= rx_data;
            state  <= LEN_HI;
          end
        end

        LEN_HI: begin
          if (xfer) begin
            if (hdr_bad) begin
              state    <= ERR;
              busy     <= 1'b0;
              done     <= 1'b0;
              error    <= 1'b1;
              cpu_hold <= 1'b1;
            end else begin
              state    <= DATA;
              length   <= hdr_len[LEN_W-1:0];
              counter  <= '0;
              checksum <= '0;
            end
          end
        end

        DATA: begin
          if (xfer) begin
            mem_we    <= 1'b1;
            mem_addr  <= counter[ADDRESS_WIDTH-1:0];
            mem_wdata <= rx_data;
            checksum  <= cksum_next;
            counter   <= counter + LEN_W'(1);
            if (last_byte) begin
              state <= CHECK;
            end
          end
        end

        CHECK: begin
          if (xfer) begin
            busy <= 1'b0;
            if (cksum_next == '0) begin
              state    <= DONE;
              done     <= 1'b1;
              error    <= 1'b0;
              cpu_hold <= 1'b0;
            end else begin
              state    <= ERR;
              done     <= 1'b0;
              error    <= 1'b1;
              cpu_hold <= 1'b1;
            end
          end
        end

        DONE, ERR: begin
          if (start) begin
            state    <= LEN_LO;
            busy     <= 1'b1;
            done     <= 1'b0;
            error    <= 1'b0;
            cpu_hold <= 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for the instruction-memory boot loader.
module tb_imem_loader;

  typedef logic [7:0] byte_q_t[$];

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        mem_we;
  logic [11:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        error;

  int vectors_applied = 0;
  int miscompares     = 0;

  logic [11:0] wr_addr_q[$];
  logic [7:0]  wr_data_q[$];

  imem_loader #(
    .ADDRESS_WIDTH(12),
    .DATA_WIDTH   (8),
    .MAX_BYTES    (4096)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .cpu_hold (cpu_hold),
    .busy     (busy),
    .done     (done),
    .error    (error)
  );

  // 10-unit clock period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Each write strobe lasts one cycle, so sampling on the falling edge logs
  // every memory write exactly once.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wr_addr_q.push_back(mem_addr);
      wr_data_q.push_back(mem_wdata);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vectors_applied++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic clearLog();
    wr_addr_q.delete();
    wr_data_q.delete();
  endtask

  task automatic pulseStart();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Offers one byte after 'gap' idle cycles and holds it until accepted.
  task automatic applyStimulus(input logic [7:0] b, input int gap);
    int waited = 0;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    while (rx_ready !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (rx_ready !== 1'b1) begin
      checkOutput("ready_timeout", {31'd0, rx_ready}, 32'd1);
      return;
    end
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic sendStream(input byte_q_t bytes, input int gap);
    foreach (bytes[i]) applyStimulus(bytes[i], gap);
  endtask

  task automatic checkStatus(input string tag, input logic exp_done, input logic exp_error,
                             input logic exp_hold, input logic exp_busy);
    checkOutput({tag, "_done"},  {31'd0, done},     {31'd0, exp_done});
    checkOutput({tag, "_error"}, {31'd0, error},    {31'd0, exp_error});
    checkOutput({tag, "_hold"},  {31'd0, cpu_hold}, {31'd0, exp_hold});
    checkOutput({tag, "_busy"},  {31'd0, busy},     {31'd0, exp_busy});
  endtask

  // Compares the logged writes against consecutive addresses from zero.
  task automatic checkWrites(input string tag, input byte_q_t exp);
    checkOutput({tag, "_wr_count"}, wr_addr_q.size(), exp.size());
    foreach (exp[i]) begin
      if (i < wr_addr_q.size()) begin
        checkOutput($sformatf("%s_addr%0d", tag, i), {20'd0, wr_addr_q[i]}, i);
        checkOutput($sformatf("%s_data%0d", tag, i), {24'd0, wr_data_q[i]}, {24'd0, exp[i]});
      end
    end
  endtask

  initial begin
    byte_q_t good_stream;
    byte_q_t bad_cksum_stream;
    byte_q_t payload;
    byte_q_t big_stream;
    logic [7:0] sum;
    logic [7:0] bval;
    int bad;

    good_stream      = '{8'h04, 8'h00, 8'h13, 8'h05, 8'h00, 8'h00, 8'hE8};
    bad_cksum_stream = '{8'h04, 8'h00, 8'h13, 8'h05, 8'h00, 8'h00, 8'h00};
    payload          = '{8'h13, 8'h05, 8'h00, 8'h00};

    rst_n    = 1'b0;
    start    = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;

    // Reset state.
    repeat (3) @(negedge clk);
    checkOutput("rst_we",    {31'd0, mem_we},    32'd0);
    checkOutput("rst_addr",  {20'd0, mem_addr},  32'd0);
    checkOutput("rst_wdata", {24'd0, mem_wdata}, 32'd0);
    checkOutput("rst_ready", {31'd0, rx_ready},  32'd0);
    checkStatus("rst", 1'b0, 1'b0, 1'b1, 1'b0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Good load of four bytes.
    clearLog();
    pulseStart();
    checkOutput("good_start_busy",  {31'd0, busy},     32'd1);
    checkOutput("good_start_ready", {31'd0, rx_ready}, 32'd1);
    sendStream(good_stream, 0);
    checkStatus("good", 1'b1, 1'b0, 1'b0, 1'b0);
    checkWrites("good", payload);

    // Bad checksum, started from DONE.
    clearLog();
    pulseStart();
    checkStatus("restart1", 1'b0, 1'b0, 1'b1, 1'b1);
    sendStream(bad_cksum_stream, 0);
    checkStatus("badck", 1'b0, 1'b1, 1'b1, 1'b0);
    checkWrites("badck", payload);

    // Zero length.
    clearLog();
    pulseStart();
    sendStream('{8'h00, 8'h00}, 0);
    checkStatus("len0", 1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("len0_ready", {31'd0, rx_ready}, 32'd0);
    repeat (2) @(negedge clk);
    checkOutput("len0_writes", wr_addr_q.size(), 32'd0);

    // Oversized length 0x1001.
    clearLog();
    pulseStart();
    sendStream('{8'h01, 8'h10}, 0);
    checkStatus("len_big", 1'b0, 1'b1, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    checkOutput("len_big_writes", wr_addr_q.size(), 32'd0);

    // Gaps between bytes, plus an ignored start in the middle of DATA.
    clearLog();
    pulseStart();
    for (int i = 0; i < 4; i++) applyStimulus(good_stream[i], 1);
    pulseStart();
    checkOutput("gap_start_ignored_busy", {31'd0, busy},     32'd1);
    checkOutput("gap_start_ignored_hold", {31'd0, cpu_hold}, 32'd1);
    for (int i = 4; i < 7; i++) applyStimulus(good_stream[i], 1);
    checkStatus("gap", 1'b1, 1'b0, 1'b0, 1'b0);
    checkWrites("gap", payload);

    // Bytes offered while not ready are neither consumed nor written.
    clearLog();
    @(negedge clk);
    rx_data  = 8'hAA;
    rx_valid = 1'b1;
    repeat (3) @(negedge clk);
    rx_valid = 1'b0;
    @(negedge clk);
    checkOutput("idle_valid_writes", wr_addr_q.size(), 32'd0);
    checkStatus("idle_valid", 1'b1, 1'b0, 1'b0, 1'b0);

    // Reset in the middle of the payload.
    clearLog();
    pulseStart();
    sendStream('{8'h04, 8'h00, 8'h13, 8'h05}, 0);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_we", {31'd0, mem_we}, 32'd0);
    checkStatus("midrst", 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    checkOutput("midrst_writes", wr_addr_q.size(), 32'd1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("midrst_idle_ready", {31'd0, rx_ready}, 32'd0);
    clearLog();
    pulseStart();
    sendStream(good_stream, 0);
    checkStatus("after_rst", 1'b1, 1'b0, 1'b0, 1'b0);
    checkWrites("after_rst", payload);

    // Restart from DONE with the largest legal payload.
    big_stream = '{8'h00, 8'h10};
    sum = 8'h00;
    for (int i = 0; i < 4096; i++) begin
      bval = 8'((i * 7 + 3) ^ (i >> 8));
      sum  = sum + bval;
      big_stream.push_back(bval);
    end
    big_stream.push_back(8'h00 - sum);
    clearLog();
    pulseStart();
    checkOutput("max_restart_hold", {31'd0, cpu_hold}, 32'd1);
    checkOutput("max_restart_done", {31'd0, done},     32'd0);
    sendStream(big_stream, 0);
    checkStatus("max", 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("max_wr_count", wr_addr_q.size(), 32'd4096);
    if (wr_addr_q.size() > 0) begin
      checkOutput("max_last_addr", {20'd0, wr_addr_q[wr_addr_q.size()-1]}, 32'hFFF);
    end
    bad = 0;
    for (int i = 0; i < wr_addr_q.size() && i < 4096; i++) begin
      if (wr_addr_q[i] !== 12'(i) || wr_data_q[i] !== big_stream[i+2]) bad++;
    end
    checkOutput("max_wr_errs", bad, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
